// File: rtl/led_pkg.sv
// Shared definitions for the LED ripple sequencer.
//   mode_e      : display modes, encoded as they appear on the mode output
//   dir_e       : bounce walk direction
//   LED_INIT    : pattern loaded on reset and on entry to rotate/bounce modes
//   LED_BLINK_INIT : pattern loaded on entry to BLINK
//   is_onehot() : legality check for single-lit-bit patterns
//   mode_succ() : mode sequencing order
package led_pkg;

    typedef enum logic [1:0] {
        MODE_RIP_L  = 2'd0,
        MODE_RIP_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [7:0] LED_INIT       = 8'h01;
    localparam logic [7:0] LED_BLINK_INIT = 8'h00;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    function automatic mode_e mode_succ(input mode_e m);
        mode_e r;
        unique case (m)
            MODE_RIP_L:  r = MODE_RIP_R;
            MODE_RIP_R:  r = MODE_BOUNCE;
            MODE_BOUNCE: r = MODE_BLINK;
            MODE_BLINK:  r = MODE_RIP_L;
            default:     r = MODE_RIP_L;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler for the LED sequencer.
// Produces a single-cycle tick every (DIV_BASE << speed) enabled clk cycles.
// Ports:
//   clk    in  1  system clock, rising edge
//   reset  in  1  synchronous active-high reset, clears the counter
//   enable in  1  count when high; counter holds and tick is suppressed when low
//   clr    in  1  restart the period (counter to 0, no tick this cycle)
//   speed  in  2  period select, period = DIV_BASE << speed
//   tick   out 1  combinational, high in the last cycle of a period
// DIV_BASE << 3 must fit below 2**CNT_W.
module led_tick_gen #(
    parameter int unsigned DIV_BASE = 50_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] limit;
    logic             at_limit;

    always_comb begin
        limit = (CNT_W'(DIV_BASE) << speed) - CNT_W'(1);
    end

    // >= rather than == so a shorter period chosen mid-count ends on the next cycle.
    assign at_limit = (cnt_q >= limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_limit ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = enable & ~clr & ~reset & at_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// 8-LED pattern sequencer: rotate-left, rotate-right, bounce and blink modes,
// stepped by a programmable prescaler tick and cycled by a mode_next pulse.
// Ports:
//   clk       in  1  system clock, rising edge
//   reset     in  1  synchronous active-high reset, overrides all other inputs
//   enable    in  1  1 = advance on tick, 0 = freeze LEDs and prescaler
//   mode_next in  1  single-cycle pulse, advance to next mode and reload pattern
//   speed     in  2  step period = DIV_BASE << speed clk cycles
//   led       out 8  LED drive, 1 = lit
//   mode      out 2  current mode (led_pkg::mode_e encoding)
//   step      out 1  high in the cycle after led updated on a tick
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned DIV_BASE = 50_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mode_next,
    input  logic [1:0] speed,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       step
);

    mode_e      mode_q, mode_d;
    dir_e       dir_q, dir_d;
    logic [7:0] led_q, led_d;
    logic       step_q, step_d;
    logic       tick;

    led_tick_gen #(
        .DIV_BASE (DIV_BASE),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clr    (mode_next),
        .speed  (speed),
        .tick   (tick)
    );

    // Mode FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_RIP_L;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode FSM: next state.
    always_comb begin
        mode_d = mode_q;
        if (mode_next) begin
            mode_d = mode_succ(mode_q);
        end
    end

    // Mode FSM: outputs.
    always_comb begin
        mode = mode_q;
    end

    // Pattern datapath. mode_next wins over a coincident tick (the prescaler also
    // suppresses tick on clr, so step stays low in that cycle).
    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        if (mode_next) begin
            led_d = (mode_d == MODE_BLINK) ? LED_BLINK_INIT : LED_INIT;
            dir_d = DIR_LEFT;
        end else if (tick) begin
            step_d = 1'b1;
            unique case (mode_q)
                MODE_RIP_L: begin
                    led_d = is_onehot(led_q) ? {led_q[6:0], led_q[7]} : LED_INIT;
                end
                MODE_RIP_R: begin
                    led_d = is_onehot(led_q) ? {led_q[0], led_q[7:1]} : LED_INIT;
                end
                MODE_BOUNCE: begin
                    if (!is_onehot(led_q)) begin
                        led_d = LED_INIT;
                        dir_d = DIR_LEFT;
                    end else if ((dir_q == DIR_LEFT && !led_q[7]) || led_q[0]) begin
                        // Moving left, or stranded on bit0 with the wrong direction.
                        led_d = {led_q[6:0], 1'b0};
                        dir_d = led_d[7] ? DIR_RIGHT : DIR_LEFT;
                    end else begin
                        led_d = {1'b0, led_q[7:1]};
                        dir_d = led_d[0] ? DIR_LEFT : DIR_RIGHT;
                    end
                end
                MODE_BLINK: begin
                    led_d = ~led_q;
                end
                default: begin
                    led_d = LED_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q  <= LED_INIT;
            dir_q  <= DIR_LEFT;
            step_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign led = led_q;
    // Gate with the live inputs so step never shows while frozen or in reset.
    assign step = step_q & enable & ~reset;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

    localparam int unsigned DivBase = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       mode_next;
    logic [1:0] speed;
    logic [7:0] led;
    logic [1:0] mode;
    logic       step;

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .DIV_BASE (DivBase),
        .CNT_W    (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode_next (mode_next),
        .speed     (speed),
        .led       (led),
        .mode      (mode),
        .step      (step)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode, ticks taken since mode entry, enabled cycles into period.
    int m_mode = 0;
    int m_k    = 0;
    int m_e    = 0;
    bit m_step = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pattern as a function of tick count since mode entry.
    function automatic logic [7:0] model_led(input int m, input int k);
        logic [7:0] one;
        int p;
        one = 8'h01;
        case (m)
            0: return one << (k % 8);
            1: return one << ((8 - (k % 8)) % 8);
            2: begin
                p = k % 14;
                return one << ((p <= 7) ? p : 14 - p);
            end
            default: return (k % 2 == 1) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic cyc(input bit r, input bit en, input bit mn, input logic [1:0] sp);
        int per;
        reset     = r;
        enable    = en;
        mode_next = mn;
        speed     = sp;
        @(posedge clk);
        per = int'(DivBase) << sp;
        if (r) begin
            m_mode = 0; m_k = 0; m_e = 0; m_step = 1'b0;
        end else if (mn) begin
            m_mode = (m_mode + 1) % 4; m_k = 0; m_e = 0; m_step = 1'b0;
        end else if (en) begin
            if (m_e >= per - 1) begin
                m_e = 0; m_k++; m_step = 1'b1;
            end else begin
                m_e++; m_step = 1'b0;
            end
        end else begin
            m_step = 1'b0;
        end
        #1;
        check("led", 32'(led), 32'(model_led(m_mode, m_k)));
        check("mode", 32'(mode), 32'(m_mode));
        check("step", 32'(step), 32'(m_step & en & !r));
    endtask

    initial begin
        logic [1:0] sp;
        // 1: reset then rotate left at speed 0
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 2'd0);
        check("reset_led", 32'(led), 32'h01);
        repeat (40) cyc(1'b0, 1'b1, 1'b0, 2'd0);

        // 2: slow speed, then drop speed at cnt=10
        cyc(1'b1, 1'b1, 1'b0, 2'd2);
        repeat (40) cyc(1'b0, 1'b1, 1'b0, 2'd2);
        cyc(1'b1, 1'b1, 1'b0, 2'd2);
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 2'd2);
        cyc(1'b0, 1'b1, 1'b0, 2'd0);
        check("speed_drop_step", 32'(step), 32'h1);
        repeat (12) cyc(1'b0, 1'b1, 1'b0, 2'd0);

        // 3-5: walk through all modes, long enough for a full bounce cycle
        repeat (4) begin
            cyc(1'b0, 1'b1, 1'b1, 2'd0);
            repeat (70) cyc(1'b0, 1'b1, 1'b0, 2'd0);
        end
        check("wrap_mode", 32'(mode), 32'h0);

        // 6: mode_next coincident with a pending tick
        for (int i = 0; i < 8 && m_e != 3; i++) cyc(1'b0, 1'b1, 1'b0, 2'd0);
        check("tick_pending", 32'(m_e), 32'd3);
        cyc(1'b0, 1'b1, 1'b1, 2'd0);
        check("coincident_step", 32'(step), 32'h0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 2'd0);
        repeat (20) cyc(1'b0, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b1, 2'd0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 2'd0);
        repeat (6) cyc(1'b0, 1'b1, 1'b0, 2'd0);
        cyc(1'b1, 1'b1, 1'b0, 2'd0);
        check("mid_reset_led", 32'(led), 32'h01);
        check("mid_reset_mode", 32'(mode), 32'h0);

        // Randomized run
        sp = 2'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 3) sp = 2'($urandom_range(3));
            cyc(($urandom_range(999) < 5), ($urandom_range(99) < 90),
                ($urandom_range(99) < 3), sp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
